// File: rtl/cell_serializer.sv
// Cell-to-stream serializer: buffers whole cells in a small circular FIFO and
// emits the head cell MSB-first as OUT_W-bit beats with sop/eop markers.
module cell_serializer #(
  parameter int CELL_W = 424,
  parameter int OUT_W  = 8,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CELL_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  // state       | meaning
  // S_EMPTY     | no cell held, outputs idle
  // S_SER       | head cell being serialized (FULL when count_q == DEPTH)

  localparam int BEATS  = (CELL_W + OUT_W - 1) / OUT_W;
  localparam int ALL_W  = BEATS * OUT_W;
  localparam int PAD    = ALL_W - CELL_W;
  localparam int LVL_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {S_EMPTY, S_SER} state_t;

  state_t              state_q, state_d;
  logic [CELL_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    count_q, count_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ALL_W-1:0]    padded;
  logic [OUT_W-1:0]    beat_word;
  logic                push, last_beat, release_cell;

  assign push         = in_valid && in_ready;
  assign last_beat    = (beat_q == BEAT_W'(BEATS - 1));
  assign release_cell = out_valid && out_ready && last_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (push) state_d = S_SER;
      S_SER:   if (release_cell && !push && count_q == LVL_W'(1)) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = (count_q < LVL_W'(DEPTH));
    out_valid = (state_q == S_SER);
    out_sop   = out_valid && (beat_q == '0);
    out_eop   = out_valid && last_beat;
    out_data  = out_valid ? beat_word : '0;
    level     = count_q;
  end

  // Left-align the cell so the pad bits land as zeros in the last beat's LSBs.
  always_comb begin
    padded    = ALL_W'(mem_q[rd_ptr_q]) << PAD;
    beat_word = '0;
    for (int b = 0; b < BEATS; b++)
      if (beat_q == BEAT_W'(b)) beat_word = padded[ALL_W-1-b*OUT_W -: OUT_W];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    beat_d   = beat_q;
    if (push)
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (out_valid && out_ready) begin
      if (last_beat) begin
        beat_d   = '0;
        rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end else begin
        beat_d   = beat_q + 1'b1;
      end
    end
    if (push && !release_cell)      count_d = count_q + 1'b1;
    else if (!push && release_cell) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      beat_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      beat_q   <= beat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: doc/cell_serializer.md
# cell_serializer

Parametrised cell-to-stream serializer for the cell output path. It accepts whole cells on a ready/valid input and buffers up to `DEPTH` cells in an internal FIFO. Each cell is emitted MSB-first as `OUT_W`-bit beats on a ready/valid output, with start- and end-of-cell markers. Both sides honour backpressure, so cells are never dropped or overwritten.

## Interface
Parameters:
- `CELL_W`, 424: cell width in bits (53 bytes); must be ≥ `OUT_W`.
- `OUT_W`, 8: output beat width in bits.
- `DEPTH`, 2: cell FIFO depth in entries; must be ≥ 1.
- Derived `BEATS` = ceil(`CELL_W`/`OUT_W`); `PAD` = `BEATS`·`OUT_W` − `CELL_W`.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_data`  in  `CELL_W`  cell; bit `CELL_W`-1 is transmitted first.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  FIFO can accept a cell this cycle.
- `out_data`  out  `OUT_W`  current beat.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink accepts the beat.
- `out_sop`  out  1  beat is beat 0 of a cell.
- `out_eop`  out  1  beat is beat `BEATS`-1 of a cell.
- `level`  out  clog2(`DEPTH`+1)  cells held, including the cell currently being serialized.

## Operation
- **Input accept:** on `in_valid && in_ready`. `in_ready` = (`level` < `DEPTH`), decoded from registered state only, with no dependence on `out_ready`.
  - When full, there is no same-cycle pass-through; a slot freed by the final beat makes `in_ready` high from the next cycle.
- **Storage:** the FIFO is a circular buffer with write pointer, read pointer and count. Pointers wrap from `DEPTH`-1 to 0.
- **Beat selection:** the head cell is serialized by beat counter `beat` (0..`BEATS`-1).
  - `out_data` = head cell bits [`CELL_W`-1-`beat`·`OUT_W` -: `OUT_W`].
  - On the last beat, the `PAD` LSBs are 0, so the cell LSBs sit in the beat MSBs.
- **Output flags:** `out_valid` = (`level` ≠ 0). `out_sop` = `out_valid` && `beat`==0. `out_eop` = `out_valid` && `beat`==`BEATS`-1. When `BEATS`==1, both flags are high on every beat.
- **Beat advance:** on `out_valid && out_ready`.
  - If `beat` < `BEATS`-1: `beat`+1.
  - Else: `beat` ← 0, the read pointer advances and the head cell is released.
- **Simultaneous push and release:** the count is unchanged, and both pointers move.
- **Output stability:** `out_data`, `out_sop` and `out_eop` hold stable while `out_valid && !out_ready`.
- **States:** EMPTY (`level`=0) and SERIALIZING (`level`>0, `beat` tracks position). FULL is the SERIALIZING sub-case `level`=`DEPTH`.

## Timing
- **Reset values:** `in_ready`=1, `out_valid`=0, `out_sop`=0, `out_eop`=0, `level`=0, `out_data`=0. `beat`, both pointers and the count are cleared.
- **Reset mid-cell:** buffered cells and the partial cell are discarded, with no eop emitted. Operation restarts at beat 0 after `rst` deasserts.
- **Latency:** a cell accepted at edge k into an empty block gives `out_valid`=1, `out_sop`=1 and beat 0 in the cycle following edge k.
- **Throughput:** one beat per cycle while `out_ready`=1. Back-to-back cells have no bubble: eop of cell n is followed in the next cycle by sop of cell n+1 when cell n+1 is buffered.
- **Full-rate input:** sustained when `DEPTH`≥2 and `BEATS`≥2.
- **Output paths:** all outputs are functions of registers only; there is no combinational in→out path.

## Test plan
- **Default config, single cell:** `in_data` = 424'h00 01 02 … 34 (byte i = i), `out_ready`=1 → 53 beats 0x00..0x34 on consecutive cycles. `out_sop` is high on beat 0 only, `out_eop` on beat 52 only. `level` goes 1 then 0 after beat 52.
- **Backpressure:** toggle `out_ready` in a 1-on/2-off pattern mid-cell → the beat sequence is identical to the stall-free case, `out_data` is held during stalls, and no beat is duplicated or skipped.
- **Full FIFO, DEPTH=2:** push 3 cells with `out_ready`=0 → the first two are accepted, `in_ready`=0 with `level`=2, and the third is held. After the 53rd beat of cell 0, `in_ready` rises the next cycle. All three cells arrive in order with no gap between eop and sop.
- **Padding, CELL_W=20, OUT_W=8:** `in_data`=20'hABCDE → 3 beats 0xAB, 0xCD, 0xE0. eop is on 0xE0.
- **Single-beat config, CELL_W=8, OUT_W=8:** stream 4 cells → 4 beats, each with `out_sop`=`out_eop`=1.
- **Reset mid-operation:** assert `rst` asynchronously at beat 20 with 1 cell queued → outputs immediately take reset values. The next cell pushed after release starts at beat 0 with sop.
